imem_loader: RTL and testbench

//   Boot-time program loader; the writer side of the single-cycle datapath's instruction memory.
//   - Accepts a byte stream from a host link (valid/ready).
//   - Assembles big-endian 32-bit words and writes them to instruction memory at consecutive word addresses.
//   - Holds the datapath in clear until the image is complete, then releases it.

---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/word_assembler.sv | 28 ++
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the instruction-memory side of the single-cycle MIPS datapath:
// loader state encoding, reset PC / base address and memory depth.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

  localparam logic [31:0] IMEM_BASE_ADDR   = 32'h0040_0000;
  localparam int          IMEM_DEPTH_WORDS = 256;

  // Byte address of instruction word idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler: first byte lands in [31:24], fourth in [7:0].
// word_out/word_valid are combinational so the word is usable at the edge the 4th byte is taken.
module word_assembler (
  input  logic        clock,
  input  logic        clear_n,
  input  logic [7:0]  byte_in,
  input  logic        take,
  output logic [31:0] word_out,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  always_ff @(negedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (take) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {shift_q[15:0], byte_in};
    end
  end

  assign word_out   = {shift_q, byte_in};
  assign word_valid = take && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length word, then N big-endian data words written to instruction memory; holds the
// datapath in clear until complete. Define IMEM_LOADER_CHECKSUM_EN to require a trailing sum word.
module imem_loader
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
  parameter int          DEPTH     = IMEM_DEPTH_WORDS,
  parameter int          CNT_W     = 9
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_clear,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  loader_state_e    state_q;
  logic             rx_ready_q;
  logic             imem_we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             cpu_clear_q;
  logic             done_q;
  logic             error_q;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] len_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      sum_q;
`endif

  logic        take;
  logic [31:0] word;
  logic        word_valid;

  assign take = rx_valid && rx_ready_q;

  word_assembler u_asm (
    .clock      (clock),
    .clear_n    (clear_n),
    .byte_in    (rx_data),
    .take       (take),
    .word_out   (word),
    .word_valid (word_valid)
  );

  // Outputs are registered alongside the state so they change only on the falling edge.
  always_ff @(negedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= LEN;
      rx_ready_q  <= 1'b1;
      imem_we_q   <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= 32'd0;
      cpu_clear_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      words_q     <= '0;
      len_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= 32'd0;
`endif
    end else begin
      case (state_q)
        LEN: begin
          if (word_valid) begin
            // Full 32-bit compare: a huge N must not alias into range after truncation.
            if (word == 32'd0 || word > 32'(DEPTH)) begin
              state_q    <= ERR;
              rx_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              state_q <= DATA;
              len_q   <= word[CNT_W-1:0];
            end
          end
        end
        DATA: begin
          if (word_valid) begin
            wdata_q    <= word;
            addr_q     <= word_addr(BASE_ADDR, 32'(words_q));
            imem_we_q  <= 1'b1;
            rx_ready_q <= 1'b0;
            state_q    <= WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_q + word;
`endif
          end
        end
        WRITE: begin
          imem_we_q <= 1'b0;
          words_q   <= words_q + CNT_W'(1);
          if (words_q + CNT_W'(1) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q     <= CSUM;
            rx_ready_q  <= 1'b1;
`else
            state_q     <= DONE;
            done_q      <= 1'b1;
            cpu_clear_q <= 1'b0;
`endif
          end else begin
            state_q    <= DATA;
            rx_ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (word_valid) begin
            rx_ready_q <= 1'b0;
            if (word == sum_q) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              cpu_clear_q <= 1'b0;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          rx_ready_q <= 1'b0;
        end
        ERR: begin
          rx_ready_q  <= 1'b0;
          imem_we_q   <= 1'b0;
          cpu_clear_q <= 1'b1;
        end
        default: begin
          state_q    <= ERR;
          rx_ready_q <= 1'b0;
          imem_we_q  <= 1'b0;
          error_q    <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_clear    = cpu_clear_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; DUT state changes on the falling edge, the bench
// samples on the rising edge. Checksum tests run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        clock;
  logic        clear_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_clear;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int checkCount = 0;
  int errCount   = 0;

  int          wrCount = 0;
  logic [31:0] wrAddr[8];
  logic [31:0] wrData[8];

  imem_loader dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_clear    (cpu_clear),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every rising-edge sample with imem_we high is one memory write cycle.
  always @(posedge clock) begin
    if (imem_we) begin
      if (wrCount < 8) begin
        wrAddr[wrCount] = imem_addr;
        wrData[wrCount] = imem_wdata;
      end
      wrCount = wrCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    @(posedge clock);
    #2 clear_n = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clock);
    #1 clear_n = 1'b1;
    wrCount = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit throttle);
    bit accepted;
    accepted = 1'b0;
    if (throttle) begin
      rx_valid = 1'b0;
      rx_data  = b ^ 8'h5A;
      @(negedge clock);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(posedge clock);
      if (rx_ready) begin
        @(negedge clock);
        #1 accepted = 1'b1;
      end
    end
    rx_valid = 1'b0;
    if (throttle) rx_data = ~b;
    if (!accepted) checkOutput("byteTimeout", 32'd0, 32'd1);
  endtask

  task automatic sendWord(input logic [31:0] w, input bit throttle);
    logic [31:0] v;
    v = w;
    applyStimulus(v[31:24], throttle);
    applyStimulus(v[23:16], throttle);
    applyStimulus(v[15:8], throttle);
    applyStimulus(v[7:0], throttle);
  endtask

  task automatic runNormal(input bit throttle);
    applyReset();
    sendWord(32'h0000_0002, throttle);
    sendWord(32'h0022_1820, throttle);
    sendWord(32'h0022_1822, throttle);
    @(posedge clock);
    checkOutput("lastWriteWe", {31'd0, imem_we}, 32'd1);
    checkOutput("lastWriteDoneLow", {31'd0, done}, 32'd0);
    @(posedge clock);
    checkOutput("weDropped", {31'd0, imem_we}, 32'd0);
    checkOutput("writeCount", wrCount, 32'd2);
    checkOutput("addr0", wrAddr[0], 32'h0040_0000);
    checkOutput("data0", wrData[0], 32'h0022_1820);
    checkOutput("addr1", wrAddr[1], 32'h0040_0004);
    checkOutput("data1", wrData[1], 32'h0022_1822);
    checkOutput("wordsLoaded", 32'(words_loaded), 32'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checkOutput("awaitCsumDone", {31'd0, done}, 32'd0);
    checkOutput("awaitCsumClear", {31'd0, cpu_clear}, 32'd1);
    checkOutput("awaitCsumReady", {31'd0, rx_ready}, 32'd1);
`else
    checkOutput("doneHigh", {31'd0, done}, 32'd1);
    checkOutput("cpuClearLow", {31'd0, cpu_clear}, 32'd0);
    checkOutput("readyLowDone", {31'd0, rx_ready}, 32'd0);
    checkOutput("errorLow", {31'd0, error}, 32'd0);
`endif
  endtask

  task automatic runBadLength(input logic [31:0] len);
    applyReset();
    sendWord(len, 1'b0);
    repeat (3) @(posedge clock);
    checkOutput("badLenError", {31'd0, error}, 32'd1);
    checkOutput("badLenReady", {31'd0, rx_ready}, 32'd0);
    checkOutput("badLenClear", {31'd0, cpu_clear}, 32'd1);
    checkOutput("badLenNoWrite", wrCount, 32'd0);
  endtask

  initial begin
    clear_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset asserted mid-clock must take effect without an edge.
    #12 clear_n = 1'b0;
    #1;
    checkOutput("rstReady", {31'd0, rx_ready}, 32'd1);
    checkOutput("rstWe", {31'd0, imem_we}, 32'd0);
    checkOutput("rstClear", {31'd0, cpu_clear}, 32'd1);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstError", {31'd0, error}, 32'd0);
    checkOutput("rstWords", 32'(words_loaded), 32'd0);
    checkOutput("rstAddr", imem_addr, 32'h0040_0000);
    checkOutput("rstWdata", imem_wdata, 32'd0);

    runNormal(1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendWord(32'h0044_3042, 1'b0);
    @(posedge clock);
    checkOutput("csumGoodDone", {31'd0, done}, 32'd1);
    checkOutput("csumGoodClear", {31'd0, cpu_clear}, 32'd0);
    checkOutput("csumNotWritten", wrCount, 32'd2);
`endif

    // cpu_clear must reassert as soon as clear_n falls, between edges.
    @(posedge clock);
    #2 clear_n = 1'b0;
    #1;
    checkOutput("asyncClear", {31'd0, cpu_clear}, 32'd1);
    checkOutput("asyncDone", {31'd0, done}, 32'd0);

    runBadLength(32'h0000_0000);
    runBadLength(32'h0000_0101);
    runBadLength(32'h8000_0001);

    runNormal(1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendWord(32'h0044_3042, 1'b1);
    @(posedge clock);
    checkOutput("csumThrottleDone", {31'd0, done}, 32'd1);
`endif

    // Reset in the middle of a data word discards the partial bytes.
    applyReset();
    sendWord(32'h0000_0002, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyReset();
    checkOutput("midRstWords", 32'(words_loaded), 32'd0);
    checkOutput("midRstReady", {31'd0, rx_ready}, 32'd1);
    sendWord(32'h0000_0001, 1'b0);
    sendWord(32'h1000_FFF2, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendWord(32'h1000_FFF2, 1'b0);
`endif
    repeat (2) @(posedge clock);
    checkOutput("midRstWriteCount", wrCount, 32'd1);
    checkOutput("midRstAddr", wrAddr[0], 32'h0040_0000);
    checkOutput("midRstData", wrData[0], 32'h1000_FFF2);
    checkOutput("midRstDone", {31'd0, done}, 32'd1);
    checkOutput("midRstClear", {31'd0, cpu_clear}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    runNormal(1'b0);
    sendWord(32'h0044_3043, 1'b0);
    repeat (2) @(posedge clock);
    checkOutput("csumBadError", {31'd0, error}, 32'd1);
    checkOutput("csumBadClear", {31'd0, cpu_clear}, 32'd1);
    checkOutput("csumBadDone", {31'd0, done}, 32'd0);
    checkOutput("csumBadWords", 32'(words_loaded), 32'd2);
    checkOutput("csumBadWrites", wrCount, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
